// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: pipeline (p_) has fixed priority,
// debug (d_) is forced in after STARVE_MAX straight losses. Optional DMEM_ARB_LOCK_EN adds d_lock.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
`ifdef DMEM_ARB_LOCK_EN
  ,
  input  logic              d_lock
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic {StArb, StResp} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       owner_q, owner_d;
  logic       grant_d, grant_p, lock_active;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  assign lock_active = lock_q & d_lock & d_req;
`else
  assign lock_active = 1'b0;
`endif

  // Grants only exist in the issue phase; RESP ignores requester inputs entirely.
  assign grant_d = (state_q == StArb) & d_req &
                   (lock_active | ~p_req | (starve_cnt_q == StarveMax));
  assign grant_p = (state_q == StArb) & p_req & ~grant_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StArb;
      starve_cnt_q <= 4'd0;
      owner_q      <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
`ifdef DMEM_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    unique case (state_q)
      StArb: begin
        if (grant_d || grant_p) begin
          state_d = StResp;
          owner_d = grant_d;
          if (grant_d || !d_req) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
`ifdef DMEM_ARB_LOCK_EN
          lock_d = grant_d & d_lock;
`endif
        end else begin
`ifdef DMEM_ARB_LOCK_EN
          lock_d = 1'b0;
`endif
        end
      end
      StResp: state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Outputs are gated by reset_n so nothing leaks out while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p_ready   = 1'b0;
    p_rdata   = '0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    if (reset_n) begin
      if (grant_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (grant_p) begin
        mem_en    = 1'b1;
        mem_we    = p_we;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
      end
      if (state_q == StResp) begin
        if (owner_q) begin
          d_ack   = 1'b1;
          d_rdata = mem_rdata;
        end else begin
          p_ready = 1'b1;
          p_rdata = mem_rdata;
        end
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle synchronous memory model.
// The lock burst section runs only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        p_req, p_we, p_ready;
  logic [7:0]  p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic        d_req, d_we, d_ack;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_en, mem_we, owner;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        d_lock;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];
  bit          preloaded = 1'b0;

  dmem_arbiter #(
    .ADDR_W(8),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_ready  (p_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner    (owner)
`ifdef DMEM_ARB_LOCK_EN
    ,
    .d_lock   (d_lock)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!preloaded) begin
      mem[3]    <= 32'hDEADBEEF;
      preloaded <= 1'b1;
    end
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = 8'h03; p_wdata = 32'h12345678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h07; d_wdata = 32'h0;
`ifdef DMEM_ARB_LOCK_EN
    d_lock = 1'b0;
`endif

    // Reset held with both requests pending
    repeat (2) begin
      step();
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_p_ready", 32'(p_ready), 32'd0);
      check("rst_d_ack", 32'(d_ack), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_p_rdata", p_rdata, 32'd0);
    end

    // Release: pipeline wins the first contested slot
    reset_n = 1'b1;
    #1;
    check("rel_mem_en", 32'(mem_en), 32'd1);
    check("rel_mem_addr", 32'(mem_addr), 32'h03);
    step();
    d_req = 1'b0;
    #1;
    check("rel_p_ready", 32'(p_ready), 32'd1);
    check("rel_p_rdata", p_rdata, 32'hDEADBEEF);
    check("rel_d_ack", 32'(d_ack), 32'd0);
    check("rel_d_rdata", d_rdata, 32'd0);
    step();

    // Pipeline-only reads, one access per two cycles
    for (int i = 0; i < 2; i++) begin
      check("p_arb_mem_en", 32'(mem_en), 32'd1);
      check("p_arb_p_ready", 32'(p_ready), 32'd0);
      step();
      check("p_resp_mem_en", 32'(mem_en), 32'd0);
      check("p_resp_p_ready", 32'(p_ready), 32'd1);
      check("p_resp_p_rdata", p_rdata, 32'hDEADBEEF);
      step();
    end

    // Starvation: P,P,P,P,D repeated
    d_req = 1'b1; d_addr = 8'h07;
    for (int i = 0; i < 10; i++) begin
      logic dw;
      dw = ((i % 5) == 4);
      #1;
      check("stv_mem_addr", 32'(mem_addr), dw ? 32'h07 : 32'h03);
      step();
      check("stv_d_ack", 32'(d_ack), 32'(dw));
      check("stv_p_ready", 32'(p_ready), 32'(!dw));
      check("stv_owner", 32'(owner), 32'(dw));
      step();
    end

    // Debug write then pipeline readback
    p_req = 1'b0; d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'h00000011;
    #1;
    check("dw_mem_we", 32'(mem_we), 32'd1);
    check("dw_mem_addr", 32'(mem_addr), 32'h05);
    check("dw_mem_wdata", mem_wdata, 32'h00000011);
    step();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check("dw_d_ack", 32'(d_ack), 32'd1);
    check("dw_owner", 32'(owner), 32'd1);
    step();
    p_req = 1'b1; p_addr = 8'h05;
    #1;
    check("pr_mem_addr", 32'(mem_addr), 32'h05);
    check("pr_mem_we", 32'(mem_we), 32'd0);
    step();
    check("pr_p_ready", 32'(p_ready), 32'd1);
    check("pr_p_rdata", p_rdata, 32'h00000011);
    p_req = 1'b0;
    step();

    // Reset during RESP of a debug read
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    #1;
    check("rr_mem_en", 32'(mem_en), 32'd1);
    step();
    reset_n = 1'b0; d_req = 1'b0;
    #1;
    check("rr_d_ack", 32'(d_ack), 32'd0);
    check("rr_d_rdata", d_rdata, 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    check("rr_owner", 32'(owner), 32'd0);
    check("rr_mem_en_idle", 32'(mem_en), 32'd0);
    p_req = 1'b1; p_addr = 8'hFF;
    #1;
    check("rr_arb_mem_en", 32'(mem_en), 32'd1);
    check("rr_addr_ff", 32'(mem_addr), 32'hFF);
    step();
    check("rr_p_ready", 32'(p_ready), 32'd1);
    p_req = 1'b0;
    step();

`ifdef DMEM_ARB_LOCK_EN
    // Locked debug burst of three writes with the pipeline waiting
    d_lock = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h00; d_wdata = 32'hA0;
    #1;
    check("lk_mem_addr0", 32'(mem_addr), 32'h00);
    step();
    p_req = 1'b1; p_addr = 8'h03; p_we = 1'b0; d_addr = 8'h01;
    #1;
    check("lk_d_ack0", 32'(d_ack), 32'd1);
    step();
    check("lk_mem_addr1", 32'(mem_addr), 32'h01);
    step();
    d_addr = 8'h02;
    #1;
    check("lk_d_ack1", 32'(d_ack), 32'd1);
    check("lk_p_ready1", 32'(p_ready), 32'd0);
    step();
    check("lk_mem_addr2", 32'(mem_addr), 32'h02);
    step();
    d_lock = 1'b0;
    #1;
    check("lk_d_ack2", 32'(d_ack), 32'd1);
    check("lk_p_ready2", 32'(p_ready), 32'd0);
    step();
    check("lk_rel_addr", 32'(mem_addr), 32'h03);
    check("lk_rel_we", 32'(mem_we), 32'd0);
    step();
    check("lk_rel_p_ready", 32'(p_ready), 32'd1);
    p_req = 1'b0; d_req = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the pipeline MEM stage (port p_) and a debug/preload port (port d_) that the benches use to load and dump DMemory.
- The pipeline has fixed priority. A starvation counter forces a debug grant after STARVE_MAX consecutive losses.
- When the pipeline is not served, p_ready stays low. The pipeline uses this as its MEM-stage stall.
- Sits between the pipeline core and the DMemory array. The memory has a synchronous read with 1-cycle latency.

Parameters:
- ADDR_W, 8, word address width of the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive pipeline wins allowed against a pending debug request. Legal range 1..15.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- p_req  in  1  pipeline access request, held until p_ready
- p_we  in  1  pipeline write enable, qualified by p_req
- p_addr  in  ADDR_W  pipeline word address
- p_wdata  in  DATA_W  pipeline write data
- p_rdata  out  DATA_W  pipeline read data, valid while p_ready=1
- p_ready  out  1  one-cycle completion pulse for the pipeline
- d_req  in  1  debug request, held until d_ack
- d_we  in  1  debug write enable
- d_addr  in  ADDR_W  debug word address
- d_wdata  in  DATA_W  debug write data
- d_rdata  out  DATA_W  debug read data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for debug
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
- owner  out  1  0 = pipeline owns the in-flight access, 1 = debug owns it

Behaviour:
- Interface: one clock named clock. Reset reset_n is synchronous and active-low. Sampled only on the rising edge of clock, and it overrides every other event.
- Reset values:
  - state = ARB, starve_cnt = 0, owner = 0.
  - p_ready = 0, d_ack = 0, mem_en = 0, mem_we = 0.
  - mem_addr, mem_wdata, p_rdata and d_rdata = 0.
- States: ARB (issue phase) and RESP (data phase).
- ARB state:
  - grant_d = d_req & (~p_req | starve_cnt == STARVE_MAX).
  - grant_p = p_req & ~grant_d.
  - If either grant is set: drive mem_en=1 and mem_we/mem_addr/mem_wdata from the winner, combinationally in the same cycle. Register owner = grant_d and go to RESP.
  - With no request: mem_en=0 and stay in ARB.
- RESP state:
  - Assert the owner's ready/ack for exactly this cycle. Route mem_rdata to the owner's rdata. The loser's ready/ack and rdata stay 0.
  - mem_en=0 in RESP. Next state is ARB unconditionally.
- Throughput and latency:
  - One access per 2 cycles.
  - Latency from request to ready is 2 cycles when uncontended.
  - A requester that holds its req through the ready/ack cycle is a new request, arbitrated in the following ARB cycle.
- Writes: complete on the mem_en cycle. The ready/ack pulse still occurs in RESP, with rdata = mem_rdata (don't-care to the requester).
- Starvation counter:
  - Width 4 bits, saturating at STARVE_MAX.
  - Updated only in ARB with a grant.
  - Increments when grant_p & d_req.
  - Clears when grant_d, or when d_req=0.
- Simultaneous requests below the limit: the pipeline wins.
- Simultaneous requests at the limit: debug wins and the counter clears.
- Requester inputs are sampled only in ARB. Changes during RESP have no effect on the in-flight access.
- Reset during RESP:
  - The in-flight access is dropped and no ready/ack is issued.
  - An already-issued write remains in memory.
- Address range: no address translation or range check. mem_addr is passed through unmodified and wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Adds input d_lock (1 bit).
  - If d_lock=1 when a debug access is granted, a lock flag sets and, in every following ARB cycle, debug is the only eligible requester while d_req=1. This gives back-to-back debug bursts.
  - The lock clears in ARB when d_lock=0 or d_req=0; arbitration that cycle uses the normal rule.
  - While the lock is set, starve_cnt holds at 0. The pipeline sees p_ready=0 for the whole burst.
  - Reset clears the lock.
- Without the macro: no d_lock port, no lock flag, pure priority-plus-starvation arbitration.

Test Plan:
- Reset values: hold reset_n=0 for 2 cycles with p_req=d_req=1 -> all outputs 0 and no mem_en. Release -> pipeline granted first, p_ready high at cycle 2.
- Pipeline-only traffic: p_req held, p_we=0, p_addr=8'h03, mem holds 32'hDEADBEEF at address 3 -> mem_en pulses every other cycle, p_ready every other cycle, p_rdata=32'hDEADBEEF.
- Starvation with STARVE_MAX=4: p_req and d_req both held continuously -> grant sequence P,P,P,P,D,P,P,P,P,D; d_ack once per 10 cycles.
- Debug write then pipeline read: d_we=1, d_addr=8'h05, d_wdata=32'h00000011 -> d_ack. Then pipeline reads address 5 -> p_rdata=32'h00000011.
- Reset in RESP: assert reset_n=0 during the RESP of a debug read -> no d_ack, owner=0 next cycle, state ARB.
- Lock burst (DMEM_ARB_LOCK_EN defined): d_lock=1 with 3 debug writes to addresses 0..2 and p_req held -> 3 consecutive d_ack with p_ready=0 throughout. Drop d_lock -> pipeline granted in the next ARB cycle.
